// File: rtl/array_0_2_port_ctrl.sv
// Requester-side controller for the single RW port of the 8192x5 SRAM macro:
// zero-fills the array after reset, then maps a request stream onto port cycles.
module array_0_2_port_ctrl #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 5,
  parameter int INIT_EN = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] mem_RW0_addr,
  output logic              mem_RW0_en,
  output logic              mem_RW0_wmode,
  output logic [DATA_W-1:0] mem_RW0_wdata,
  input  logic [DATA_W-1:0] mem_RW0_rdata
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam state_t RESET_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  logic stall;
  logic accept;
  logic capture;

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    stall         = 1'b0;
    accept        = 1'b0;
    req_ready     = 1'b0;
    mem_RW0_en    = 1'b0;
    mem_RW0_wmode = 1'b0;
    mem_RW0_addr  = '0;
    mem_RW0_wdata = '0;

    case (state_q)
      ST_INIT: begin
        mem_RW0_en    = 1'b1;
        mem_RW0_wmode = 1'b1;
        mem_RW0_addr  = init_cnt_q;
        mem_RW0_wdata = INIT_VALUE;
        if (init_cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + ONE;
        end
      end
      ST_RUN: begin
        // Holding the port idle while stalled keeps the pending read data on the macro output.
        stall     = rd_pend_q && resp_valid_q && !resp_ready;
        req_ready = !stall;
        accept    = req_valid && !stall;
        if (accept) begin
          mem_RW0_en    = 1'b1;
          mem_RW0_wmode = req_write;
          mem_RW0_addr  = req_addr;
          mem_RW0_wdata = req_wdata;
        end
      end
    endcase

    if (!reset_n) begin
      req_ready     = 1'b0;
      accept        = 1'b0;
      mem_RW0_en    = 1'b0;
      mem_RW0_wmode = 1'b0;
      mem_RW0_addr  = '0;
      mem_RW0_wdata = '0;
    end

    // A write accepted alongside the capture commits after it, so the capture sees old data.
    capture      = rd_pend_q && !stall;
    rd_pend_d    = (accept && !req_write) || stall;
    resp_valid_d = capture || (resp_valid_q && !resp_ready);
    resp_data_d  = capture ? mem_RW0_rdata : resp_data_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= RESET_STATE;
      init_cnt_q   <= '0;
      rd_pend_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      rd_pend_q    <= rd_pend_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign init_done  = (state_q == ST_RUN);

endmodule

// File: tb/tb_array_0_2_port_ctrl.sv
// Directed bench for array_0_2_port_ctrl with a behavioural model of the
// 8192x5 single-port macro (registered read, output held between reads).
module tb_array_0_2_port_ctrl;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 5;
  localparam int DEPTH  = 8192;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              init_done;
  logic [ADDR_W-1:0] mem_RW0_addr;
  logic              mem_RW0_en;
  logic              mem_RW0_wmode;
  logic [DATA_W-1:0] mem_RW0_wdata;
  logic [DATA_W-1:0] mem_RW0_rdata;

  logic [DATA_W-1:0] mem_array [0:DEPTH-1];
  logic              preload;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  array_0_2_port_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_EN(1), .INIT_VALUE(5'h00)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .init_done(init_done),
    .mem_RW0_addr(mem_RW0_addr), .mem_RW0_en(mem_RW0_en),
    .mem_RW0_wmode(mem_RW0_wmode), .mem_RW0_wdata(mem_RW0_wdata),
    .mem_RW0_rdata(mem_RW0_rdata)
  );

  // Macro model; preload fills it with non-zero junk so the fill is observable.
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem_array[i] <= 5'h1F;
      mem_RW0_rdata <= '0;
    end else if (mem_RW0_en) begin
      if (mem_RW0_wmode) mem_array[mem_RW0_addr] <= mem_RW0_wdata;
      else               mem_RW0_rdata <= mem_array[mem_RW0_addr];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic test_reset();
    int fill_bad;
    int nonzero;
    reset_n = 1'b0; preload = 1'b1; resp_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    tick();
    preload = 1'b0;
    tick();
    @(negedge clock);
    checks++;
    if ({mem_RW0_en, mem_RW0_wmode, mem_RW0_addr, mem_RW0_wdata} !== 20'h0) begin
      errors++; $display("FAIL reset_port: got en=%b addr=%h required all 0", mem_RW0_en, mem_RW0_addr);
    end
    checks++;
    if ({resp_valid, resp_data, init_done, req_ready} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got valid=%b data=%h done=%b ready=%b required 0 0 0 0",
                         resp_valid, resp_data, init_done, req_ready);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    fill_bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      if ({mem_RW0_en, mem_RW0_wmode, mem_RW0_addr, mem_RW0_wdata} !== {1'b1, 1'b1, 13'(i), 5'h00} ||
          req_ready !== 1'b0 || init_done !== 1'b0) begin
        if (fill_bad == 0)
          $display("FAIL fill_cycle: cycle %0d got en=%b wm=%b addr=%h wd=%h ready=%b done=%b required 1 1 %h 00 0 0",
                   i, mem_RW0_en, mem_RW0_wmode, mem_RW0_addr, mem_RW0_wdata, req_ready, init_done, 13'(i));
        fill_bad++;
      end
      tick();
    end
    checks++;
    if (fill_bad != 0) begin
      errors++; $display("FAIL fill_seq: got %0d bad cycles required 0", fill_bad);
    end
    @(negedge clock);
    checks++;
    if ({init_done, req_ready, mem_RW0_en} !== 3'b110) begin
      errors++; $display("FAIL after_fill: got done=%b ready=%b en=%b required 1 1 0", init_done, req_ready, mem_RW0_en);
    end
    nonzero = 0;
    for (int i = 0; i < DEPTH; i++) if (mem_array[i] !== 5'h00) nonzero++;
    checks++;
    if (nonzero != 0) begin
      errors++; $display("FAIL array_zero: got %0d non-zero entries required 0", nonzero);
    end
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    tick(); drive(1'b1, 1'b1, 13'h0005, 5'h1A);
    @(negedge clock);
    checks++;
    if ({req_ready, mem_RW0_en, mem_RW0_wmode, mem_RW0_addr, mem_RW0_wdata} !== {1'b1, 1'b1, 1'b1, 13'h0005, 5'h1A}) begin
      errors++; $display("FAIL wr_pass: got rdy=%b en=%b wm=%b addr=%h wd=%h required 1 1 1 0005 1a",
                         req_ready, mem_RW0_en, mem_RW0_wmode, mem_RW0_addr, mem_RW0_wdata);
    end
    tick(); drive(1'b1, 1'b0, 13'h0005, 5'h00);
    @(negedge clock);
    checks++;
    if ({mem_RW0_en, mem_RW0_wmode, mem_RW0_addr} !== {1'b1, 1'b0, 13'h0005}) begin
      errors++; $display("FAIL rd_pass: got en=%b wm=%b addr=%h required 1 0 0005", mem_RW0_en, mem_RW0_wmode, mem_RW0_addr);
    end
    tick(); drive(1'b0, 1'b0, '0, '0);
    @(negedge clock);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL rd_lat1: got resp_valid=%b required 0", resp_valid);
    end
    tick();
    @(negedge clock);
    checks++;
    if ({resp_valid, resp_data} !== {1'b1, 5'h1A}) begin
      errors++; $display("FAIL rd_lat2: got valid=%b data=%h required 1 1a", resp_valid, resp_data);
    end
    tick();
    @(negedge clock);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL rd_drain: got resp_valid=%b required 0", resp_valid);
    end
    $display("test_write_read done");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      tick(); drive(1'b1, 1'b1, 13'(k + 1), 5'(k + 1));
    end
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k < 4) drive(1'b1, 1'b0, 13'(k + 1), 5'h00);
      else       drive(1'b0, 1'b0, '0, '0);
      @(negedge clock);
      checks++;
      if (k >= 2 && k <= 5) begin
        if ({resp_valid, resp_data} !== {1'b1, 5'(k - 1)}) begin
          errors++; $display("FAIL b2b_data: cycle %0d got valid=%b data=%h required 1 %h", k, resp_valid, resp_data, 5'(k - 1));
        end
      end else if (resp_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_idle: cycle %0d got valid=%b required 0", k, resp_valid);
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_stall();
    resp_ready = 1'b0;
    tick(); drive(1'b1, 1'b0, 13'h0001, 5'h00);
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL stall_acc0: got req_ready=%b required 1", req_ready);
    end
    tick(); drive(1'b1, 1'b0, 13'h0002, 5'h00);
    @(negedge clock);
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      errors++; $display("FAIL stall_acc1: got ready=%b valid=%b required 1 0", req_ready, resp_valid);
    end
    for (int s = 0; s < 5; s++) begin
      tick(); drive(1'b1, 1'b0, 13'h0003, 5'h00);
      @(negedge clock);
      checks++;
      if ({req_ready, mem_RW0_en, resp_valid, resp_data} !== {1'b0, 1'b0, 1'b1, 5'h01}) begin
        errors++; $display("FAIL stall_hold: cycle %0d got ready=%b en=%b valid=%b data=%h required 0 0 1 01",
                           s, req_ready, mem_RW0_en, resp_valid, resp_data);
      end
    end
    tick(); resp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({req_ready, mem_RW0_en, mem_RW0_addr, resp_valid, resp_data} !== {1'b1, 1'b1, 13'h0003, 1'b1, 5'h01}) begin
      errors++; $display("FAIL stall_release: got ready=%b en=%b addr=%h valid=%b data=%h required 1 1 0003 1 01",
                         req_ready, mem_RW0_en, mem_RW0_addr, resp_valid, resp_data);
    end
    tick(); drive(1'b0, 1'b0, '0, '0);
    @(negedge clock);
    checks++;
    if ({resp_valid, resp_data} !== {1'b1, 5'h02}) begin
      errors++; $display("FAIL stall_order2: got valid=%b data=%h required 1 02", resp_valid, resp_data);
    end
    tick();
    @(negedge clock);
    checks++;
    if ({resp_valid, resp_data} !== {1'b1, 5'h03}) begin
      errors++; $display("FAIL stall_order3: got valid=%b data=%h required 1 03", resp_valid, resp_data);
    end
    tick();
    @(negedge clock);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL stall_end: got valid=%b required 0", resp_valid);
    end
    $display("test_stall done");
  endtask

  task automatic test_read_before_write();
    tick(); drive(1'b1, 1'b1, 13'h0010, 5'h07);
    tick(); drive(1'b1, 1'b0, 13'h0010, 5'h00);
    tick(); drive(1'b1, 1'b1, 13'h0010, 5'h09);
    @(negedge clock);
    checks++;
    if ({req_ready, mem_RW0_en, mem_RW0_wmode} !== 3'b111) begin
      errors++; $display("FAIL rbw_wr_acc: got ready=%b en=%b wm=%b required 1 1 1", req_ready, mem_RW0_en, mem_RW0_wmode);
    end
    tick(); drive(1'b0, 1'b0, '0, '0);
    @(negedge clock);
    checks++;
    if ({resp_valid, resp_data} !== {1'b1, 5'h07}) begin
      errors++; $display("FAIL rbw_old: got valid=%b data=%h required 1 07", resp_valid, resp_data);
    end
    tick(); drive(1'b1, 1'b0, 13'h0010, 5'h00);
    tick(); drive(1'b0, 1'b0, '0, '0);
    tick();
    @(negedge clock);
    checks++;
    if ({resp_valid, resp_data} !== {1'b1, 5'h09}) begin
      errors++; $display("FAIL rbw_new: got valid=%b data=%h required 1 09", resp_valid, resp_data);
    end
    tick();
    $display("test_read_before_write done");
  endtask

  task automatic test_reset_mid();
    int fill_bad;
    resp_ready = 1'b0;
    tick(); drive(1'b1, 1'b1, 13'h0020, 5'h0B);
    tick(); drive(1'b1, 1'b0, 13'h0020, 5'h00);
    tick(); drive(1'b1, 1'b0, 13'h0020, 5'h00);
    tick(); drive(1'b0, 1'b0, '0, '0); reset_n = 1'b0;
    @(negedge clock);
    checks++;
    if ({resp_valid, resp_data, mem_RW0_en} !== {1'b1, 5'h0B, 1'b0}) begin
      errors++; $display("FAIL mid_pre: got valid=%b data=%h en=%b required 1 0b 0", resp_valid, resp_data, mem_RW0_en);
    end
    tick(); reset_n = 1'b1; resp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({resp_valid, resp_data, init_done, req_ready} !== 8'h00) begin
      errors++; $display("FAIL mid_reset: got valid=%b data=%h done=%b ready=%b required 0 00 0 0",
                         resp_valid, resp_data, init_done, req_ready);
    end
    checks++;
    if ({mem_RW0_en, mem_RW0_wmode, mem_RW0_addr, mem_RW0_wdata} !== {1'b1, 1'b1, 13'h0000, 5'h00}) begin
      errors++; $display("FAIL mid_fill0: got en=%b wm=%b addr=%h wd=%h required 1 1 0000 00",
                         mem_RW0_en, mem_RW0_wmode, mem_RW0_addr, mem_RW0_wdata);
    end
    fill_bad = 0;
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      @(negedge clock);
      if ({mem_RW0_en, mem_RW0_wmode, mem_RW0_addr} !== {1'b1, 1'b1, 13'(i)} || resp_valid !== 1'b0) fill_bad++;
    end
    checks++;
    if (fill_bad != 0) begin
      errors++; $display("FAIL mid_fill_seq: got %0d bad cycles required 0", fill_bad);
    end
    tick();
    @(negedge clock);
    checks++;
    if ({init_done, resp_valid} !== 2'b10) begin
      errors++; $display("FAIL mid_done: got done=%b valid=%b required 1 0", init_done, resp_valid);
    end
    tick(); drive(1'b1, 1'b0, 13'h0020, 5'h00);
    tick(); drive(1'b0, 1'b0, '0, '0);
    tick();
    @(negedge clock);
    checks++;
    if ({resp_valid, resp_data} !== {1'b1, 5'h00}) begin
      errors++; $display("FAIL mid_cleared: got valid=%b data=%h required 1 00", resp_valid, resp_data);
    end
    tick();
    @(negedge clock);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_no_stale: got valid=%b required 0", resp_valid);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_stall();
    test_read_before_write();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
